// File: rtl/pcs_rx_sync_decode_pkg.sv
// Shared 8B/10B code tables, comma patterns, sync state encodings and
// running-disparity helpers for the PCS receive decoder and sync FSM.
package pcs_rx_sync_decode_pkg;

    // Bits a..g of the two comma forms
    localparam logic [6:0] COMMA_POS = 7'b0011111;
    localparam logic [6:0] COMMA_NEG = 7'b1100000;

    // K28 6b sub-block in the RD- column
    localparam logic [5:0] K28_6B = 6'b001111;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        ACQUIRE_SYNC_1,
        COMMA_DETECT_2,
        ACQUIRE_SYNC_2,
        COMMA_DETECT_3,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_4A
    } sync_state_t;

    // rd_col[0]: found in RD- column, rd_col[1]: found in RD+ column
    typedef struct packed {
        logic       valid;
        logic [1:0] rd_col;
        logic       is_k;
        logic [7:0] octet;
    } lut_out_t;

    typedef struct packed {
        logic       found;
        logic       is_k;
        logic [7:0] octet;
    } col_hit_t;

    // 5b/6b code (abcdei) for the RD- column
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        logic [5:0] c;
        unique case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // RD+ form is the complement when the code is unbalanced or D.7
    function automatic logic [5:0] enc6(
        input logic [4:0] x,
        input logic       rd_pos
    );
        logic [5:0] c;
        c = enc6_neg(x);
        if (rd_pos && (($countones(c) != 3) || (x == 5'd7)))
            c = ~c;
        return c;
    endfunction

    // 3b/4b code (fghj) given RD entering the 4b sub-block.
    // Balanced data codes are RD-independent except y=3; K codes
    // always flip with RD.
    function automatic logic [3:0] enc4(
        input logic [2:0] y,
        input logic       r6_pos,
        input logic       k,
        input logic       alt7
    );
        logic [3:0] b;
        logic       dep;
        unique case (y)
            3'd0: b = 4'b0100;
            3'd1: b = 4'b1001;
            3'd2: b = 4'b0101;
            3'd3: b = 4'b0011;
            3'd4: b = 4'b0010;
            3'd5: b = 4'b1010;
            3'd6: b = 4'b0110;
            default: b = (k || alt7) ? 4'b1000 : 4'b0001;
        endcase
        dep = k || (y == 3'd0) || (y == 3'd3)
            || (y == 3'd4) || (y == 3'd7);
        return (dep && !r6_pos) ? ~b : b;
    endfunction

    function automatic logic rd_6b(
        input logic [5:0] c,
        input logic       rd
    );
        logic r;
        r = rd;
        if ($countones(c) > 3)       r = 1'b1;
        else if ($countones(c) < 3)  r = 1'b0;
        else if (c == 6'b000111)     r = 1'b1;
        else if (c == 6'b111000)     r = 1'b0;
        return r;
    endfunction

    function automatic logic rd_4b(
        input logic [3:0] c,
        input logic       rd
    );
        logic r;
        r = rd;
        if ($countones(c) > 2)       r = 1'b1;
        else if ($countones(c) < 2)  r = 1'b0;
        else if (c == 4'b0011)       r = 1'b1;
        else if (c == 4'b1100)       r = 1'b0;
        return r;
    endfunction

    function automatic logic is_comma(input logic [9:0] cg);
        return (cg[9:3] == COMMA_POS) || (cg[9:3] == COMMA_NEG);
    endfunction

endpackage

// File: rtl/pcs_rx_decode_lut.sv
// Combinational 10B -> {valid, rd_col, is_k, octet} lookup over both
// RD columns.  Ports: code_group (abcdei fghj), lut (decode result).
module pcs_rx_decode_lut
    import pcs_rx_sync_decode_pkg::*;
(
    input  logic [9:0] code_group,
    output lut_out_t   lut
);

    // Membership test for one RD column: match the 6b sub-block, then
    // re-encode the 4b sub-block with the RD left by the 6b block.
    function automatic col_hit_t col_search(
        input logic [9:0] cg,
        input logic       rd_pos
    );
        col_hit_t   h;
        logic [5:0] c6;
        logic [3:0] c4;
        logic [4:0] x;
        logic       f6;
        logic       k28;
        logic       r6;
        logic       alt7;
        logic       kx;
        h   = '0;
        c6  = cg[9:4];
        c4  = cg[3:0];
        f6  = 1'b0;
        x   = 5'd0;
        k28 = (c6 == (rd_pos ? ~K28_6B : K28_6B));
        for (int i = 0; i < 32; i++) begin
            if (enc6(5'(i), rd_pos) == c6) begin
                f6 = 1'b1;
                x  = 5'(i);
            end
        end
        if (k28) begin
            f6 = 1'b1;
            x  = 5'd28;
        end
        r6   = rd_6b(c6, rd_pos);
        // D.x.A7 avoids a run of five in the alternate 4b form
        alt7 = r6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                  : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        kx   = k28 || (x == 5'd23) || (x == 5'd27)
            || (x == 5'd29) || (x == 5'd30);
        for (int j = 0; j < 8; j++) begin
            if (f6 && !k28
                && enc4(3'(j), r6, 1'b0, alt7) == c4) begin
                h.found = 1'b1;
                h.is_k  = 1'b0;
                h.octet = {3'(j), x};
            end
            if (f6 && kx && (k28 || j == 7)
                && enc4(3'(j), r6, 1'b1, 1'b0) == c4) begin
                h.found = 1'b1;
                h.is_k  = 1'b1;
                h.octet = {3'(j), x};
            end
        end
        return h;
    endfunction

    col_hit_t hit_neg;
    col_hit_t hit_pos;

    always_comb begin
        hit_neg    = col_search(code_group, 1'b0);
        hit_pos    = col_search(code_group, 1'b1);
        lut.valid  = hit_neg.found || hit_pos.found;
        lut.rd_col = {hit_pos.found, hit_neg.found};
        lut.is_k   = hit_neg.found ? hit_neg.is_k : hit_pos.is_k;
        lut.octet  = hit_neg.found ? hit_neg.octet : hit_pos.octet;
    end

endmodule

// File: rtl/pcs_rx_sync_decode.sv
// PCS receive 8B/10B decoder with running disparity and link sync FSM.
// Inputs: GTX_CLK, mr_main_reset (async, high), rx_code_group_10b,
// rx_cg_valid.  Outputs: code_group_8b, rx_is_k, rx_code_error,
// rx_even, rx_dv, sync_status; code_err_count when PCS_RX_ERR_CNT_EN
// is defined.
module pcs_rx_sync_decode
    import pcs_rx_sync_decode_pkg::*;
#(
    parameter int GOOD_CGS_MAX = 3
`ifdef PCS_RX_ERR_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] rx_code_group_10b,
    input  logic       rx_cg_valid,
    output logic [7:0] code_group_8b,
    output logic       rx_is_k,
    output logic       rx_code_error,
    output logic       rx_even,
    output logic       rx_dv,
    output logic       sync_status
`ifdef PCS_RX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] code_err_count
`endif
);

    lut_out_t    lut;
    sync_state_t state;
    sync_state_t state_nx;
    logic [1:0]  good_cgs;
    logic [1:0]  good_cgs_nx;
    logic        rd_pos;
    logic        rd_mid;
    logic        rd_next;
    logic        comma;
    logic        cg_bad;
    logic        cg_data;
    logic        disp_err;
    logic        code_err;
    logic        even_nx;
    logic        sync_nx;

    pcs_rx_decode_lut u_lut (
        .code_group (rx_code_group_10b),
        .lut        (lut)
    );

    assign comma    = is_comma(rx_code_group_10b);
    assign cg_bad   = !lut.valid || (comma && rx_even);
    assign cg_data  = lut.valid && !lut.is_k;
    assign disp_err = lut.valid
        && !(rd_pos ? lut.rd_col[1] : lut.rd_col[0]);
    assign code_err = !lut.valid || disp_err;
    assign rd_mid   = rd_6b(rx_code_group_10b[9:4], rd_pos);
    assign rd_next  = rd_4b(rx_code_group_10b[3:0], rd_mid);

    function automatic logic [1:0] gc_inc(input logic [1:0] g);
        return (g == 2'b11) ? g : g + 2'd1;
    endfunction

    always_comb begin
        state_nx    = state;
        good_cgs_nx = 2'd0;
        unique case (state)
            LOSS_OF_SYNC:
                if (comma) state_nx = COMMA_DETECT_1;
            COMMA_DETECT_1:
                state_nx = cg_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2:
                state_nx = cg_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3:
                state_nx = cg_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1:
                if (cg_bad)                state_nx = LOSS_OF_SYNC;
                else if (comma && !rx_even) state_nx = COMMA_DETECT_2;
            ACQUIRE_SYNC_2:
                if (cg_bad)                state_nx = LOSS_OF_SYNC;
                else if (comma && !rx_even) state_nx = COMMA_DETECT_3;
            SYNC_ACQUIRED_1:
                if (cg_bad) state_nx = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2:
                if (cg_bad) state_nx = SYNC_ACQUIRED_3;
                else begin
                    state_nx    = SYNC_ACQUIRED_2A;
                    good_cgs_nx = 2'd1;
                end
            SYNC_ACQUIRED_3:
                if (cg_bad) state_nx = SYNC_ACQUIRED_4;
                else begin
                    state_nx    = SYNC_ACQUIRED_3A;
                    good_cgs_nx = 2'd1;
                end
            SYNC_ACQUIRED_4:
                if (cg_bad) state_nx = LOSS_OF_SYNC;
                else begin
                    state_nx    = SYNC_ACQUIRED_4A;
                    good_cgs_nx = 2'd1;
                end
            SYNC_ACQUIRED_2A:
                if (cg_bad) state_nx = SYNC_ACQUIRED_3;
                else if (good_cgs == 2'(GOOD_CGS_MAX))
                    state_nx = SYNC_ACQUIRED_1;
                else good_cgs_nx = gc_inc(good_cgs);
            SYNC_ACQUIRED_3A:
                if (cg_bad) state_nx = SYNC_ACQUIRED_4;
                else if (good_cgs == 2'(GOOD_CGS_MAX))
                    state_nx = SYNC_ACQUIRED_2;
                else good_cgs_nx = gc_inc(good_cgs);
            SYNC_ACQUIRED_4A:
                if (cg_bad) state_nx = LOSS_OF_SYNC;
                else if (good_cgs == 2'(GOOD_CGS_MAX))
                    state_nx = SYNC_ACQUIRED_3;
                else good_cgs_nx = gc_inc(good_cgs);
            default:
                state_nx = LOSS_OF_SYNC;
        endcase
    end

    // A comma-detect state always marks the group just taken as even
    assign even_nx = (state_nx inside {COMMA_DETECT_1,
        COMMA_DETECT_2, COMMA_DETECT_3}) ? 1'b1 : !rx_even;

    assign sync_nx = state_nx inside {SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            code_group_8b <= 8'd0;
            rx_is_k       <= 1'b0;
            rx_code_error <= 1'b0;
            rx_even       <= 1'b0;
            rx_dv         <= 1'b0;
            sync_status   <= 1'b0;
            rd_pos        <= 1'b0;
            state         <= LOSS_OF_SYNC;
            good_cgs      <= 2'd0;
        end else begin
            rx_dv <= rx_cg_valid;
            if (rx_cg_valid) begin
                code_group_8b <= lut.octet;
                rx_is_k       <= lut.is_k;
                rx_code_error <= code_err;
                rx_even       <= even_nx;
                sync_status   <= sync_nx;
                rd_pos        <= rd_next;
                state         <= state_nx;
                good_cgs      <= good_cgs_nx;
            end
        end
    end

`ifdef PCS_RX_ERR_CNT_EN
    // Restart counting at each new sync attempt
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            code_err_count <= '0;
        end else if (rx_cg_valid) begin
            if (state == LOSS_OF_SYNC && state_nx == COMMA_DETECT_1)
                code_err_count <= '0;
            else if (code_err && code_err_count != '1)
                code_err_count <= code_err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pcs_rx_sync_decode.sv
// Directed self-checking bench for pcs_rx_sync_decode.
// Drives code groups and checks the registered output bundle.
module tb_pcs_rx_sync_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cg;
    logic       cgv;
    logic [7:0] code_group_8b;
    logic       rx_is_k;
    logic       rx_code_error;
    logic       rx_even;
    logic       rx_dv;
    logic       sync_status;
`ifdef PCS_RX_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [9:0] K285N = 10'b0011111010;
    localparam logic [9:0] K285P = 10'b1100000101;
    localparam logic [9:0] D162N = 10'b0110110101;
    localparam logic [9:0] D162P = 10'b1001000101;
    localparam logic [9:0] BADCG = 10'b0000000000;

    always #5 clk = ~clk;

    pcs_rx_sync_decode dut (
        .GTX_CLK           (clk),
        .mr_main_reset     (rst),
        .rx_code_group_10b (cg),
        .rx_cg_valid       (cgv),
        .code_group_8b     (code_group_8b),
        .rx_is_k           (rx_is_k),
        .rx_code_error     (rx_code_error),
        .rx_even           (rx_even),
        .rx_dv             (rx_dv),
        .sync_status       (sync_status)
`ifdef PCS_RX_ERR_CNT_EN
        ,
        .code_err_count    (err_cnt)
`endif
    );

    // {octet, k, err, even, dv, sync}
    logic [12:0] obs;
    assign obs = {code_group_8b, rx_is_k, rx_code_error,
                  rx_even, rx_dv, sync_status};

    function automatic logic [12:0] ob(
        input logic [7:0] d,
        input logic k, e, ev, dv, s
    );
        return {d, k, e, ev, dv, s};
    endfunction

    task automatic send(input logic [9:0] c);
        cg  = c;
        cgv = 1'b1;
        @(posedge clk);
        #1;
        cgv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cgv = 1'b0;
        cg  = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, 13'd0);
        end
`ifdef PCS_RX_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%h want=0", err_cnt);
        end
`endif
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", obs, 13'd0);
        end
    endtask

    task automatic test_sync();
        logic [9:0]  s [6];
        logic [12:0] e [6];
        logic [12:0] w;
        s = '{K285N, D162P, K285N, D162P, K285N, D162P};
        e[0] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[1] = ob(8'h50, 0, 0, 0, 1, 0);
        e[2] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[3] = ob(8'h50, 0, 0, 0, 1, 0);
        e[4] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[5] = ob(8'h50, 0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            send(s[i]);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sync[%0d] got=%h want=%h",
                         i, obs, e[i]);
            end
            if (i == 3) begin
                // garbage on an unqualified cycle must be ignored
                cg = BADCG;
                repeat (2) @(posedge clk);
                #1;
                w = ob(8'h50, 0, 0, 0, 0, 0);
                checks++;
                if (obs !== w) begin
                    errors++;
                    $display("FAIL idle_hold got=%h want=%h", obs, w);
                end
            end
        end
    endtask

    task automatic test_error_recovery();
        logic [9:0]  s [9];
        logic [12:0] e [9];
        s = '{BADCG, D162N, D162P, D162N, D162P,
              BADCG, BADCG, BADCG, BADCG};
        e[0] = ob(8'h00, 0, 1, 1, 1, 1);
        e[1] = ob(8'h50, 0, 0, 0, 1, 1);
        e[2] = ob(8'h50, 0, 0, 1, 1, 1);
        e[3] = ob(8'h50, 0, 0, 0, 1, 1);
        e[4] = ob(8'h50, 0, 0, 1, 1, 1);
        e[5] = ob(8'h00, 0, 1, 0, 1, 1);
        e[6] = ob(8'h00, 0, 1, 1, 1, 1);
        e[7] = ob(8'h00, 0, 1, 0, 1, 1);
        e[8] = ob(8'h00, 0, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            send(s[i]);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL err_rec[%0d] got=%h want=%h",
                         i, obs, e[i]);
            end
        end
    endtask

    task automatic test_disparity();
        logic [12:0] w;
        send(K285N);
        w = ob(8'hBC, 1, 0, 1, 1, 0);
        checks++;
        if (obs !== w) begin
            errors++;
            $display("FAIL disp_first got=%h want=%h", obs, w);
        end
        send(K285N);
        w = ob(8'hBC, 1, 1, 0, 1, 0);
        checks++;
        if (obs !== w) begin
            errors++;
            $display("FAIL disp_wrong_col got=%h want=%h", obs, w);
        end
    endtask

    task automatic test_odd_comma();
        logic [9:0]  s [11];
        logic [12:0] e [11];
        s = '{K285P, D162N, D162P, K285N, D162P, K285N,
              D162P, K285N, D162P, K285N, D162P};
        e[0]  = ob(8'hBC, 1, 0, 1, 1, 0);
        e[1]  = ob(8'h50, 0, 0, 0, 1, 0);
        e[2]  = ob(8'h50, 0, 0, 1, 1, 0);
        e[3]  = ob(8'hBC, 1, 0, 0, 1, 0);
        e[4]  = ob(8'h50, 0, 0, 1, 1, 0);
        e[5]  = ob(8'hBC, 1, 0, 1, 1, 0);
        e[6]  = ob(8'h50, 0, 0, 0, 1, 0);
        e[7]  = ob(8'hBC, 1, 0, 1, 1, 0);
        e[8]  = ob(8'h50, 0, 0, 0, 1, 0);
        e[9]  = ob(8'hBC, 1, 0, 1, 1, 0);
        e[10] = ob(8'h50, 0, 0, 0, 1, 1);
        for (int i = 0; i < 11; i++) begin
            send(s[i]);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL odd_comma[%0d] got=%h want=%h",
                         i, obs, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0]  s [6];
        logic [12:0] e [6];
        logic [12:0] w;
        send(K285N);
        w = ob(8'hBC, 1, 0, 1, 1, 1);
        checks++;
        if (obs !== w) begin
            errors++;
            $display("FAIL pre_reset got=%h want=%h", obs, w);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs, 13'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        s = '{K285N, D162P, K285N, D162P, K285N, D162P};
        e[0] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[1] = ob(8'h50, 0, 0, 0, 1, 0);
        e[2] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[3] = ob(8'h50, 0, 0, 0, 1, 0);
        e[4] = ob(8'hBC, 1, 0, 1, 1, 0);
        e[5] = ob(8'h50, 0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            send(s[i]);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL resync[%0d] got=%h want=%h",
                         i, obs, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_error_recovery();
        test_disparity();
        test_odd_comma();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcs_rx_sync_decode.md
Name: pcs_rx_sync_decode

Overview:
- Receive-side counterpart of the PCS 8B/10B transmit encoder (1000BASE-X, clause 36 style).
- Accepts one aligned 10-bit code group per clock and tracks running disparity (RD).
- Decodes to 8 bits plus a control flag, and runs the synchronization state machine that declares link sync OK or FAIL.
- Sits between the PMA deserializer and the PCS receive state machine.

Parameters:
GOOD_CGS_MAX, 3, consecutive good code groups needed to step back one error level in the SYNC_ACQUIRED states.
CNT_W, 16, width of the optional error counter.

Ports:
GTX_CLK  in  1  code-group clock; all state on rising edge.
mr_main_reset  in  1  asynchronous, active-high reset.
rx_code_group_10b  in  10  received code group; bit9=a … bit0=j (abcdei fghj).
rx_cg_valid  in  1  qualifies rx_code_group_10b this cycle.
code_group_8b  out  8  decoded octet (HGF EDCBA).
rx_is_k  out  1  decoded group is a special (K) code.
rx_code_error  out  1  invalid code group or disparity error.
rx_even  out  1  current group occupies an even position.
rx_dv  out  1  outputs valid this cycle.
sync_status  out  1  1=OK (any SYNC_ACQUIRED state), 0=FAIL.

Behaviour:
- Reset (async, active-high):
  - code_group_8b=0, rx_is_k=0, rx_code_error=0, rx_dv=0, rx_even=0, sync_status=0.
  - RD=negative, state=LOSS_OF_SYNC, good_cgs=0.
- Latency:
  - Outputs are registered, 1 cycle after an accepted input (rx_cg_valid=1).
  - rx_dv is the delayed rx_cg_valid.
  - Cycles with rx_cg_valid=0 change no state.
- Decode:
  - Look up the group in both RD columns of the shared code table.
  - Found in neither column: code_group_8b=0, rx_is_k=0, rx_code_error=1 (cginvalid).
  - Found only in the column opposite current RD: decode normally but assert rx_code_error (disparity error).
- RD update:
  - Per sub-block, 6b first, then 4b.
  - Ones count > half → RD positive; < half → RD negative.
  - Balanced → RD unchanged, except 000111 → positive, 111000 → negative, 0011 → positive, 1100 → negative.
  - RD updates on invalid groups too, using the same rule.
- Comma: bits a..g equal 0011111 or 1100000.
- Definitions:
  - cgbad = invalid OR (comma AND rx_even==1).
  - cggood = valid AND NOT (comma AND rx_even==1).
- rx_even:
  - Toggles on every accepted group.
  - Forced to 1 in every COMMA_DETECT state.
- Sync FSM, evaluated on each accepted group:
  - LOSS_OF_SYNC: comma → COMMA_DETECT_1.
  - COMMA_DETECT_n: valid data group → ACQUIRE_SYNC_n (n=1,2); from COMMA_DETECT_3 → SYNC_ACQUIRED_1. Otherwise → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_n: cgbad → LOSS_OF_SYNC; comma with rx_even==0 → COMMA_DETECT_(n+1); else stay.
  - SYNC_ACQUIRED_1: cgbad → SYNC_ACQUIRED_2.
  - SYNC_ACQUIRED_k (k=2..4): cgbad → k+1 (from k=4 → LOSS_OF_SYNC); cggood → k A with good_cgs=1.
  - SYNC_ACQUIRED_kA:
    - cgbad → k+1 (from 4A → LOSS_OF_SYNC).
    - cggood with good_cgs==GOOD_CGS_MAX → k-1 (2A → SYNC_ACQUIRED_1); else good_cgs++.
- good_cgs is a 2-bit counter; it saturates and never wraps.
- rx_code_error is reported regardless of sync state.
- Simultaneous comma + disparity error counts as cgbad only if the group is invalid or mispositioned.

Optional Feature:
PCS_RX_ERR_CNT_EN:
- Defined: adds output code_err_count [CNT_W-1:0].
  - Increments on each accepted group with rx_code_error=1.
  - Saturates at all-ones.
  - Cleared by reset and on each LOSS_OF_SYNC → COMMA_DETECT_1 transition.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package/include (extend the existing table include):
  - 10B codes for both RD columns.
  - 8B values and K flags.
  - Comma patterns.
  - Sync state encodings.
- Sub-module pcs_rx_decode_lut: combinational 10B → {valid, rd_col, is_k, 8b} lookup.
- The top level holds RD, the FSM, rx_even, good_cgs and output registers.

Test Plan:
- Reset, then K28.5 0011111010 (RD-) + D16.2 1001000101 (RD+) ×3 pairs → sync_status=1 after the 6th group's output. Outputs 0xBC/k=1 and 0x50/k=0, no errors.
- In sync, inject one 0000000000 → rx_code_error=1, state SYNC_ACQUIRED_2, sync_status stays 1. Then 4 good groups → SYNC_ACQUIRED_1.
- In sync, 4 consecutive invalid groups → sync_status=0 on the output of the 4th.
- After valid K28.5 (RD- column, RD now +), send K28.5 0011111010 again (wrong column) → rx_code_error=1, code_group_8b=0xBC.
- Send comma at an odd position (rx_even==1) while in ACQUIRE_SYNC_1 → LOSS_OF_SYNC.
- Assert mr_main_reset mid-stream during sync → all outputs 0 immediately (async), RD=negative. Resync requires 3 fresh comma/data pairs.
